// File: rtl/angle_seg_display.sv
// Samples a signed 9-bit angle once per refresh period, converts its magnitude to BCD with a
// sequential double-dabble engine and drives sign/hundreds/tens/units seven-segment displays.
module angle_seg_display #(
    parameter int REFRESH_CYCLES = 5_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [8:0] i_angle,
    output logic [7:0] o_hex0,
    output logic [7:0] o_hex1,
    output logic [7:0] o_hex2,
    output logic [7:0] o_hex3,
    output logic       o_busy,
    output logic       o_done
);
    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_sign;
    logic [8:0]    r_mag;
    logic [11:0]   r_bcd;
    logic [3:0]    r_iter;

    logic          w_tick;
    logic [8:0]    w_mag;
    logic [11:0]   w_bcd_adj;

    assign w_tick = (r_count == LAST);
    assign w_mag  = i_angle[8] ? 9'(-i_angle) : i_angle;
    assign o_busy = (r_state != S_IDLE);

    // Add-3 correction applied to every BCD nibble before each shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
        end
    endgenerate

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en || w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
            o_hex0  <= 8'hC0;
            o_hex1  <= 8'hFF;
            o_hex2  <= 8'hFF;
            o_hex3  <= 8'hFF;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick && i_en) begin
                        r_sign  <= i_angle[8];
                        r_mag   <= w_mag;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_mag} <= {w_bcd_adj[10:0], r_mag, 1'b0};
                    r_iter         <= r_iter + 4'd1;
                    if (r_iter == 4'd8) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // All four digits commit on the same edge so the readout never tears.
                    o_hex0  <= seg7(r_bcd[3:0]);
                    o_hex1  <= (r_bcd[11:4] == 8'd0) ? 8'hFF : seg7(r_bcd[7:4]);
                    o_hex2  <= (r_bcd[11:8] == 4'd0) ? 8'hFF : seg7(r_bcd[11:8]);
                    o_hex3  <= (r_sign && (r_bcd != 12'd0)) ? 8'hBF : 8'hFF;
                    o_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_angle_seg_display.sv
// Directed and randomized checks of angle_seg_display against a decimal-arithmetic display model.
module tb_angle_seg_display;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [8:0] angle = '0;
    logic [7:0] hex0, hex1, hex2, hex3;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    angle_seg_display #(.REFRESH_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_angle(angle),
        .o_hex0(hex0), .o_hex1(hex1), .o_hex2(hex2), .o_hex3(hex3),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] digit_seg(input int d);
        logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tbl[d];
    endfunction

    // Expected {hex3,hex2,hex1,hex0} from plain decimal arithmetic.
    function automatic logic [31:0] model(input logic [8:0] a);
        int v, mag, h, t, u;
        logic [7:0] s3, s2, s1, s0;
        v   = a[8] ? int'(a) - 512 : int'(a);
        mag = (v < 0) ? -v : v;
        h = mag / 100;
        t = (mag / 10) % 10;
        u = mag % 10;
        s3 = (v < 0) ? 8'hBF : 8'hFF;
        s2 = (h == 0) ? 8'hFF : digit_seg(h);
        s1 = (h == 0 && t == 0) ? 8'hFF : digit_seg(t);
        s0 = digit_seg(u);
        return {s3, s2, s1, s0};
    endfunction

    // Steps until o_done is seen; k is the number of edges taken (bound+1 on timeout).
    task automatic wait_done(input int bound, output int k, output int busy_cnt, output int overlap);
        busy_cnt = 0;
        overlap  = 0;
        for (k = 1; k <= bound; k++) begin
            step();
            if (busy && done) overlap++;
            if (done) break;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_refresh(input string tag, input logic [8:0] a);
        int k, bc, ov;
        angle = a;
        wait_done(40, k, bc, ov);
        chk({tag, "_period"}, k, 16);
        chk({tag, "_busy"}, bc, 10);
        chk({tag, "_hex"}, {hex3, hex2, hex1, hex0}, model(a));
        $display("refresh %s angle=%0d hex=%h %h %h %h period=%0d", tag, $signed(a),
                 hex3, hex2, hex1, hex0, k);
    endtask

    initial begin
        int k, bc, ov, stray;

        // Reset with enable low
        repeat (5) step();
        rst = 1'b0;
        chk("reset_hex", {hex3, hex2, hex1, hex0}, 32'hFFFFFFC0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        stray = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (done || busy) stray++;
        end
        chk("idle_no_activity", stray, 0);

        // First conversion from enable rise
        en = 1'b1;
        angle = 9'd45;
        wait_done(60, k, bc, ov);
        chk("first_latency", k, 26);
        chk("first_busy", bc, 10);
        chk("first_overlap", ov, 0);
        chk("first_hex", {hex3, hex2, hex1, hex0}, 32'hFFFF9992);
        $display("first angle=45 latency=%0d hex=%h %h %h %h", k, hex3, hex2, hex1, hex0);

        // Directed values on successive refreshes
        run_refresh("m135", 9'(-135));
        chk("m135_const", {hex3, hex2, hex1, hex0}, 32'hBFF9B092);
        run_refresh("m5", 9'(-5));
        chk("m5_const", {hex3, hex2, hex1, hex0}, 32'hBFFFFF92);
        run_refresh("zero", 9'd0);
        chk("zero_const", {hex3, hex2, hex1, hex0}, 32'hFFFFFFC0);
        run_refresh("m256", 9'h100);
        chk("m256_const", {hex3, hex2, hex1, hex0}, 32'hBFA49282);
        run_refresh("p180", 9'd180);
        chk("p180_const", {hex3, hex2, hex1, hex0}, 32'hFFF980C0);

        // Random angles
        for (int i = 0; i < 12; i++) begin
            run_refresh($sformatf("rnd%0d", i), 9'($urandom_range(0, 511)));
        end

        // Input change and enable drop during a conversion
        angle = 9'd45;
        repeat (6) step();
        chk("mid_busy_start", busy, 1);
        repeat (3) step();
        angle = 9'(-100);
        repeat (2) step();
        en = 1'b0;
        wait_done(20, k, bc, ov);
        chk("mid_latency", k, 5);
        chk("mid_hex", {hex3, hex2, hex1, hex0}, 32'hFFFF9992);
        $display("mid-change done hex=%h %h %h %h", hex3, hex2, hex1, hex0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) stray++;
        end
        chk("disabled_quiet", stray, 0);
        en = 1'b1;
        angle = 9'd7;
        wait_done(60, k, bc, ov);
        chk("reenable_latency", k, 26);
        chk("reenable_hex", {hex3, hex2, hex1, hex0}, model(9'd7));

        // Reset during a conversion of 123
        angle = 9'd123;
        repeat (6) step();
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_hex", {hex3, hex2, hex1, hex0}, 32'hFFFFFFC0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        wait_done(60, k, bc, ov);
        chk("postrst_latency", k, 26);
        chk("postrst_hex", {hex3, hex2, hex1, hex0}, 32'hFFF9A4B0);
        $display("post-reset angle=123 latency=%0d hex=%h %h %h %h", k, hex3, hex2, hex1, hex0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
